// File: rtl/tq_coef_rd_ctrl.sv
// -----------------------------------------------------------------------------
// tq_coef_rd_ctrl
//
// Read-side controller for the TQ coefficient RAM (port B, read-only). A run of
// consecutive rows is fetched, where each row holds one 4x4 block of 16
// coefficients. Each block goes to the entropy-coding stage over a valid/ready
// handshake, tagged with its run index, its non-zero coefficient count and a
// last-of-run marker. A 2-entry output FIFO absorbs the RAM's 1-cycle read
// latency. This sustains one block per cycle while blk_ready_i stays high.
//
// Ports
//   clk, rst_n     clock; synchronous active-low reset
//   start_i        1-cycle pulse that begins a run (ignored unless idle)
//   base_addr_i    first row of the run, sampled with start_i
//   num_rows_i     number of rows in the run (0..64), sampled with start_i
//   busy_o         run in progress
//   done_o         1-cycle pulse when the run has completed
//   rd_b_o         RAM port B read enable
//   raddr_b_o      RAM port B read address (registered, wraps 63 -> 0)
//   rdata_b_i      RAM port B read data, valid the cycle after rd_b_o
//   blk_valid_o    output block valid
//   blk_ready_i    downstream ready; a transfer is valid & ready
//   blk_data_o     block coefficients, coef k at bits [COEF_W*k +: COEF_W]
//   blk_idx_o      0-based index of the block within the run
//   blk_nnz_o      number of non-zero coefficients in the block (0..16)
//   blk_last_o     final block of the run
// -----------------------------------------------------------------------------
module tq_coef_rd_ctrl #(
  parameter int COEF_W = 16,
  parameter int ADDR_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [ADDR_W-1:0]    base_addr_i,
  input  logic [ADDR_W:0]      num_rows_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 rd_b_o,
  output logic [ADDR_W-1:0]    raddr_b_o,
  input  logic [16*COEF_W-1:0] rdata_b_i,
  output logic                 blk_valid_o,
  input  logic                 blk_ready_i,
  output logic [16*COEF_W-1:0] blk_data_o,
  output logic [ADDR_W-1:0]    blk_idx_o,
  output logic [4:0]           blk_nnz_o,
  output logic                 blk_last_o
);

  localparam int NCOEF = 16;
  localparam int ROW_W = NCOEF * COEF_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Run bookkeeping
  logic [ADDR_W:0]   count_reg;      // rows in the current run
  logic [ADDR_W:0]   rows_left_reg;  // rows not yet issued to the RAM
  logic [ADDR_W-1:0] addr_reg;       // next RAM row to read
  logic [ADDR_W-1:0] cap_idx_reg;    // run index of the next captured row
  logic              inflight_reg;   // RAM data returns this cycle

  // Output FIFO: slot 0 is always the head, so the outputs never need a mux
  logic [1:0]        buf_cnt_reg, buf_cnt_next;
  logic [ROW_W-1:0]  slot_data_reg [2];
  logic [ADDR_W-1:0] slot_idx_reg  [2];
  logic [4:0]        slot_nnz_reg  [2];
  logic              slot_last_reg [2];

  logic              pop;
  logic              push;
  logic              push_to_head;
  logic [2:0]        occ_after;
  logic [NCOEF-1:0]  coef_nz;
  logic [4:0]        nnz_calc;
  logic              last_calc;

  // ---------------------------------------------------------------------------
  // Non-zero count of the returning row, computed as it is captured
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NCOEF; gi++) begin : g_nz
      assign coef_nz[gi] = |rdata_b_i[gi*COEF_W +: COEF_W];
    end
  endgenerate

  always_comb begin
    nnz_calc = '0;
    for (int k = 0; k < NCOEF; k++) begin
      nnz_calc = nnz_calc + 5'(coef_nz[k]);
    end
  end

  assign last_calc = ({1'b0, cap_idx_reg} == (count_reg - (ADDR_W+1)'(1)));

  // ---------------------------------------------------------------------------
  // Handshake, issue decision and next state
  // ---------------------------------------------------------------------------
  assign blk_valid_o = (buf_cnt_reg != 2'd0);
  assign blk_data_o  = slot_data_reg[0];
  assign blk_idx_o   = slot_idx_reg[0];
  assign blk_nnz_o   = slot_nnz_reg[0];
  assign blk_last_o  = slot_last_reg[0];
  assign raddr_b_o   = addr_reg;

  always_comb begin
    pop          = blk_valid_o & blk_ready_i;
    push         = inflight_reg;
    // Occupancy once this cycle's returning row is stored and any pop is
    // taken. A new read is only issued when its row is sure to find a free
    // slot. The decision uses this cycle's live handshake, so a stall never
    // lets a third row be requested. With ready held high it still issues
    // every cycle.
    occ_after    = 3'(buf_cnt_reg) + 3'(inflight_reg) - 3'(pop);
    buf_cnt_next = 2'(occ_after);
    push_to_head = (buf_cnt_reg == 2'd0) || ((buf_cnt_reg == 2'd1) && pop);

    rd_b_o     = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    state_next = state_reg;

    case (state_reg)
      S_IDLE: begin
        if (start_i) begin
          state_next = (num_rows_i != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        busy_o = 1'b1;
        rd_b_o = (rows_left_reg != '0) && (occ_after < 3'd2);
        // Finished once every row is issued, nothing returns and the FIFO
        // drains with this cycle's pop.
        if ((rows_left_reg == '0) && !inflight_reg && (buf_cnt_next == 2'd0)) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        done_o     = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register and run counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      count_reg     <= '0;
      rows_left_reg <= '0;
      addr_reg      <= '0;
      cap_idx_reg   <= '0;
      inflight_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= rd_b_o;
      if ((state_reg == S_IDLE) && start_i) begin
        count_reg     <= num_rows_i;
        rows_left_reg <= num_rows_i;
        addr_reg      <= base_addr_i;
        cap_idx_reg   <= '0;
      end else begin
        if (rd_b_o) begin
          rows_left_reg <= rows_left_reg - (ADDR_W+1)'(1);
          addr_reg      <= addr_reg + ADDR_W'(1);   // natural wrap 63 -> 0
        end
        if (push) begin
          cap_idx_reg <= cap_idx_reg + ADDR_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_cnt_reg <= 2'd0;
      for (int k = 0; k < 2; k++) begin
        slot_data_reg[k] <= '0;
        slot_idx_reg[k]  <= '0;
        slot_nnz_reg[k]  <= '0;
        slot_last_reg[k] <= 1'b0;
      end
    end else begin
      buf_cnt_reg <= buf_cnt_next;
      if (pop) begin
        slot_data_reg[0] <= slot_data_reg[1];
        slot_idx_reg[0]  <= slot_idx_reg[1];
        slot_nnz_reg[0]  <= slot_nnz_reg[1];
        slot_last_reg[0] <= slot_last_reg[1];
      end
      if (push) begin
        if (push_to_head) begin
          slot_data_reg[0] <= rdata_b_i;
          slot_idx_reg[0]  <= cap_idx_reg;
          slot_nnz_reg[0]  <= nnz_calc;
          slot_last_reg[0] <= last_calc;
        end else begin
          slot_data_reg[1] <= rdata_b_i;
          slot_idx_reg[1]  <= cap_idx_reg;
          slot_nnz_reg[1]  <= nnz_calc;
          slot_last_reg[1] <= last_calc;
        end
      end
    end
  end

endmodule

// File: tb/tb_tq_coef_rd_ctrl.sv
module tb_tq_coef_rd_ctrl;

  localparam int ROW_W = 256;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start_i;
  logic [5:0]       base_addr_i;
  logic [6:0]       num_rows_i;
  logic             busy_o, done_o, rd_b_o;
  logic [5:0]       raddr_b_o;
  logic [ROW_W-1:0] rdata_b_i;
  logic             blk_valid_o, blk_ready_i;
  logic [ROW_W-1:0] blk_data_o;
  logic [5:0]       blk_idx_o;
  logic [4:0]       blk_nnz_o;
  logic             blk_last_o;

  tq_coef_rd_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .num_rows_i  (num_rows_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .rd_b_o      (rd_b_o),
    .raddr_b_o   (raddr_b_o),
    .rdata_b_i   (rdata_b_i),
    .blk_valid_o (blk_valid_o),
    .blk_ready_i (blk_ready_i),
    .blk_data_o  (blk_data_o),
    .blk_idx_o   (blk_idx_o),
    .blk_nnz_o   (blk_nnz_o),
    .blk_last_o  (blk_last_o)
  );

  always #5 clk = ~clk;

  // RAM model: 1-cycle registered read
  logic [ROW_W-1:0] mem [64];
  always @(posedge clk) if (rd_b_o) rdata_b_i <= mem[raddr_b_o];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: the expected block stream of a run, built from RAM contents
  typedef struct {
    logic [ROW_W-1:0] d;
    int               idx;
    int               nnz;
    bit               last;
  } blk_t;

  blk_t expq[$];
  bit   m_on = 0;
  int   m_base, m_num, m_reads, m_pops;
  int   first_valid_cyc, done_cyc;
  int   acc_nnz[$], acc_idx[$], acc_last[$], acc_cyc[$], raddr_log[$];

  function automatic int spec_nnz(input logic [ROW_W-1:0] r);
    int n = 0;
    for (int k = 0; k < 16; k++) if (r[k*16 +: 16] != 16'd0) n++;
    return n;
  endfunction

  function automatic logic [ROW_W-1:0] rand_row();
    logic [ROW_W-1:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Per-cycle comparison against the model, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n && m_on) begin
      if (rd_b_o) begin
        check("raddr", 256'(raddr_b_o), 256'((m_base + m_reads) % 64));
        check("rd_beyond_run", 256'(m_reads < m_num), 256'(1));
        raddr_log.push_back(int'(raddr_b_o));
        m_reads++;
      end
      if (blk_valid_o) begin
        if (expq.size() == 0) begin
          check("valid_without_block", 256'(blk_valid_o), 256'(0));
        end else begin
          check("blk_data", blk_data_o, expq[0].d);
          check("blk_idx", 256'(blk_idx_o), 256'(expq[0].idx));
          check("blk_nnz", 256'(blk_nnz_o), 256'(expq[0].nnz));
          check("blk_last", 256'(blk_last_o), 256'(expq[0].last));
          if (first_valid_cyc < 0) first_valid_cyc = cyc;
          if (blk_ready_i) begin
            acc_nnz.push_back(int'(blk_nnz_o));
            acc_idx.push_back(int'(blk_idx_o));
            acc_last.push_back(int'(blk_last_o));
            acc_cyc.push_back(cyc);
            void'(expq.pop_front());
            m_pops++;
          end
        end
      end
      check("outstanding_le2", 256'((m_reads - m_pops) <= 2), 256'(1));
      if (done_o) begin
        done_cyc = cyc;
        check("done_blocks_left", 256'(expq.size()), 256'(0));
      end
    end
  end

  // One run: tog toggles ready every cycle, ign pulses start while busy and in DONE
  task automatic run(input int base, input int num, input bit tog, input bit ign, output int t0);
    expq.delete(); acc_nnz.delete(); acc_idx.delete(); acc_last.delete();
    acc_cyc.delete(); raddr_log.delete();
    for (int i = 0; i < num; i++) begin
      blk_t b;
      b.d    = mem[(base + i) % 64];
      b.idx  = i;
      b.nnz  = spec_nnz(b.d);
      b.last = (i == num - 1);
      expq.push_back(b);
    end
    m_base = base; m_num = num; m_reads = 0; m_pops = 0;
    first_valid_cyc = -1; done_cyc = -1; m_on = 1;
    @(posedge clk); #1;
    start_i = 1; base_addr_i = 6'(base); num_rows_i = 7'(num); t0 = cyc;
    @(posedge clk); #1;
    start_i = 0;
    check("busy_after_start", 256'(busy_o), 256'(num > 0));
    for (int k = 0; k < 300 && done_cyc < 0; k++) begin
      start_i = ign && (k == 3 || done_o);
      base_addr_i = 6'd40; num_rows_i = 7'd3;
      if (tog) blk_ready_i = ~blk_ready_i;
      @(posedge clk); #1;
    end
    start_i = 0;
    check("done_seen", 256'(done_cyc >= 0), 256'(1));
    check("done_one_cycle", 256'(done_o), 256'(0));
    @(posedge clk); #1;
    check("idle_busy", 256'(busy_o), 256'(0));
    check("idle_rd", 256'(rd_b_o), 256'(0));
    check("blocks_missing", 256'(expq.size()), 256'(0));
    check("reads_count", 256'(m_reads), 256'(num));
    m_on = 0;
    blk_ready_i = 1;
  endtask

  int t0;

  initial begin
    rst_n = 0; start_i = 0; base_addr_i = '0; num_rows_i = '0; blk_ready_i = 1;
    for (int r = 0; r < 64; r++) mem[r] = rand_row();
    for (int r = 0; r < 4; r++) mem[r] = '0;
    mem[2][15:0] = 16'd5;
    mem[30] = {16{16'h8000}};
    mem[31] = '0;
    mem[31][255:240] = 16'h0001;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 256'(busy_o), 256'(0));
    check("rst_done", 256'(done_o), 256'(0));
    check("rst_rd", 256'(rd_b_o), 256'(0));
    check("rst_valid", 256'(blk_valid_o), 256'(0));
    check("rst_last", 256'(blk_last_o), 256'(0));
    check("rst_raddr", 256'(raddr_b_o), 256'(0));
    check("rst_data", blk_data_o, 256'(0));
    check("rst_idx", 256'(blk_idx_o), 256'(0));
    check("rst_nnz", 256'(blk_nnz_o), 256'(0));
    rst_n = 1;

    // 1: four blocks back to back, one non-zero coefficient in row 2
    run(0, 4, 0, 0, t0);
    check("t1_first_valid_T3", 256'(first_valid_cyc - t0), 256'(3));
    check("t1_done_T7", 256'(done_cyc - t0), 256'(7));
    check("t1_count", 256'(acc_nnz.size()), 256'(4));
    for (int i = 0; i < acc_nnz.size(); i++) begin
      check("t1_pop_cycle", 256'(acc_cyc[i] - t0), 256'(3 + i));
      check("t1_nnz", 256'(acc_nnz[i]), 256'((i == 2) ? 1 : 0));
      check("t1_last", 256'(acc_last[i]), 256'(i == 3));
    end

    // 2: address wrap
    run(62, 4, 0, 0, t0);
    check("t2_reads", 256'(raddr_log.size()), 256'(4));
    for (int i = 0; i < raddr_log.size(); i++)
      check("t2_raddr", 256'(raddr_log[i]), 256'((i < 2) ? 62 + i : i - 2));
    for (int i = 0; i < acc_idx.size(); i++)
      check("t2_idx", 256'(acc_idx[i]), 256'(i));

    // 3: ready toggling, starts while busy and in DONE ignored
    blk_ready_i = 0;
    run(8, 8, 1, 1, t0);
    check("t3_count", 256'(acc_idx.size()), 256'(8));
    for (int i = 0; i < acc_idx.size(); i++)
      check("t3_idx_order", 256'(acc_idx[i]), 256'(i));

    // 4: empty run
    run(7, 0, 0, 0, t0);
    check("t4_done_T1", 256'(done_cyc - t0), 256'(1));
    check("t4_no_valid", 256'(first_valid_cyc), 256'(-1));

    // 5: nnz extremes
    run(30, 2, 0, 0, t0);
    check("t5_count", 256'(acc_nnz.size()), 256'(2));
    for (int i = 0; i < acc_nnz.size(); i++)
      check("t5_nnz", 256'(acc_nnz[i]), 256'((i == 0) ? 16 : 1));

    // 6: reset mid-run with a read in flight
    blk_ready_i = 0;
    @(posedge clk); #1;
    start_i = 1; base_addr_i = 6'd20; num_rows_i = 7'd6;
    @(posedge clk); #1;
    start_i = 0;
    check("t6_rd_T1", 256'(rd_b_o), 256'(1));
    @(posedge clk); #1;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    check("t6_busy", 256'(busy_o), 256'(0));
    check("t6_done", 256'(done_o), 256'(0));
    check("t6_rd", 256'(rd_b_o), 256'(0));
    check("t6_valid", 256'(blk_valid_o), 256'(0));
    check("t6_last", 256'(blk_last_o), 256'(0));
    check("t6_raddr", 256'(raddr_b_o), 256'(0));
    check("t6_data", blk_data_o, 256'(0));
    check("t6_idx", 256'(blk_idx_o), 256'(0));
    check("t6_nnz", 256'(blk_nnz_o), 256'(0));
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("t6_no_done", 256'(done_o), 256'(0));
      check("t6_no_valid", 256'(blk_valid_o), 256'(0));
    end
    blk_ready_i = 1;
    run(5, 3, 0, 0, t0);
    check("t6_clean_count", 256'(acc_idx.size()), 256'(3));
    check("t6_clean_done_T6", 256'(done_cyc - t0), 256'(6));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
